// File: rtl/apb_timer_pkg.sv
// Shared register map, TCR bit positions and bus/register-select types for the APB timer.
// The ISR decode is present only when APB_TIMER_IRQ_EN is defined.
package apb_timer_pkg;

  localparam logic [4:0] ADDR_TCR  = 5'h00;
  localparam logic [4:0] ADDR_TCNT = 5'h04;
  localparam logic [4:0] ADDR_PSC  = 5'h08;
  localparam logic [4:0] ADDR_ARR  = 5'h0C;
  localparam logic [4:0] ADDR_ISR  = 5'h10;

  localparam int TCR_EN_BIT  = 0;
  localparam int TCR_CLR_BIT = 1;
  localparam int ISR_OVF_BIT = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TCR,
    SEL_TCNT,
    SEL_PSC,
    SEL_ARR,
    SEL_ISR
  } reg_sel_e;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_e;

  // Full 5-bit compare, so misaligned offsets fall through to SEL_NONE.
  function automatic reg_sel_e decode_addr(input logic [4:0] addr);
    reg_sel_e sel;
    case (addr)
      ADDR_TCR:  sel = SEL_TCR;
      ADDR_TCNT: sel = SEL_TCNT;
      ADDR_PSC:  sel = SEL_PSC;
      ADDR_ARR:  sel = SEL_ARR;
`ifdef APB_TIMER_IRQ_EN
      ADDR_ISR:  sel = SEL_ISR;
`endif
      default:   sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/apb_timer_core.sv
// Prescaler, counter and overflow flag of the APB timer.
// The OVF flag and its clear input exist only when APB_TIMER_IRQ_EN is defined.
module apb_timer_core
  import apb_timer_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] psc,
  input  logic [31:0] arr,
  output logic [31:0] tcnt
`ifdef APB_TIMER_IRQ_EN
  ,
  input  logic        ovf_clr,
  output logic        ovf
`endif
);

  logic [31:0] presc_reg, presc_next;
  logic [31:0] tcnt_reg, tcnt_next;
  logic        tick;
  logic        wrap;

  always_comb begin
    tick       = en && (presc_reg >= psc);
    wrap       = tick && !clr && (tcnt_reg >= arr);
    presc_next = presc_reg;
    tcnt_next  = tcnt_reg;
    // A clear beats a coincident tick.
    if (clr) begin
      presc_next = 32'd0;
      tcnt_next  = 32'd0;
    end else if (en) begin
      presc_next = tick ? 32'd0 : presc_reg + 32'd1;
      if (tick) begin
        tcnt_next = wrap ? 32'd0 : tcnt_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      presc_reg <= 32'd0;
      tcnt_reg  <= 32'd0;
    end else begin
      presc_reg <= presc_next;
      tcnt_reg  <= tcnt_next;
    end
  end

  assign tcnt = tcnt_reg;

`ifdef APB_TIMER_IRQ_EN
  logic ovf_reg, ovf_next;

  // Setting wins over a simultaneous write-1-to-clear.
  always_comb begin
    ovf_next = ovf_reg;
    if (wrap) begin
      ovf_next = 1'b1;
    end else if (ovf_clr) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: rtl/apb_timer_slave.sv
// APB slave with one wait state wrapping the timer core: bus FSM plus register file.
// Define APB_TIMER_IRQ_EN to add the ISR register and the irq output.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter logic [31:0] RESET_ARR = 32'hFFFF_FFFF
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [4:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY
`ifdef APB_TIMER_IRQ_EN
  ,
  output logic        irq
`endif
);

  bus_state_e  state_reg, state_next;
  reg_sel_e    sel;
  logic        commit, wr_commit, rd_commit;

  logic        en_reg, en_next;
  logic [31:0] psc_reg, psc_next;
  logic [31:0] arr_reg, arr_next;
  logic [31:0] prdata_reg, prdata_next;
  logic [31:0] rdata;
  logic        clr_pulse;
  logic [31:0] tcnt;
`ifdef APB_TIMER_IRQ_EN
  logic        ovf;
  logic        ovf_clr;
`endif

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_reg <= BUS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = BUS_IDLE;
    if (state_reg == BUS_IDLE && PSEL && PENABLE) begin
      state_next = BUS_ACK;
    end
  end

  // The commit cycle is the first access cycle; PREADY follows one cycle later.
  always_comb begin
    commit    = (state_reg == BUS_IDLE) && PSEL && PENABLE;
    wr_commit = commit && PWRITE;
    rd_commit = commit && !PWRITE;
  end

  assign PREADY = (state_reg == BUS_ACK);
  assign sel    = decode_addr(PADDR);

  always_comb begin
    en_next   = en_reg;
    psc_next  = psc_reg;
    arr_next  = arr_reg;
    clr_pulse = 1'b0;
`ifdef APB_TIMER_IRQ_EN
    ovf_clr   = 1'b0;
`endif
    if (wr_commit) begin
      case (sel)
        SEL_TCR: begin
          en_next   = PWDATA[TCR_EN_BIT];
          clr_pulse = PWDATA[TCR_CLR_BIT];
        end
        SEL_PSC: psc_next = PWDATA;
        SEL_ARR: arr_next = PWDATA;
`ifdef APB_TIMER_IRQ_EN
        SEL_ISR: ovf_clr = PWDATA[ISR_OVF_BIT];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (sel)
      SEL_TCNT: rdata = tcnt;
      SEL_PSC:  rdata = psc_reg;
      SEL_ARR:  rdata = arr_reg;
`ifdef APB_TIMER_IRQ_EN
      SEL_ISR:  rdata = {31'd0, ovf};
`endif
      default:  rdata = 32'd0;
    endcase
    prdata_next = rd_commit ? rdata : prdata_reg;
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      en_reg     <= 1'b0;
      psc_reg    <= 32'd0;
      arr_reg    <= RESET_ARR;
      prdata_reg <= 32'd0;
    end else begin
      en_reg     <= en_next;
      psc_reg    <= psc_next;
      arr_reg    <= arr_next;
      prdata_reg <= prdata_next;
    end
  end

  assign PRDATA = prdata_reg;

  apb_timer_core u_core (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .en      (en_reg),
    .clr     (clr_pulse),
    .psc     (psc_reg),
    .arr     (arr_reg),
    .tcnt    (tcnt)
`ifdef APB_TIMER_IRQ_EN
    ,
    .ovf_clr (ovf_clr),
    .ovf     (ovf)
`endif
  );

`ifdef APB_TIMER_IRQ_EN
  assign irq = ovf;
`endif

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave; irq/ISR checks are compiled in with APB_TIMER_IRQ_EN.
module tb_apb_timer_slave;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
`ifdef APB_TIMER_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  apb_timer_slave #(.RESET_ARR(32'hFFFF_FFFF)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
`ifdef APB_TIMER_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Setup edge, commit edge, then the edge on which PREADY drops again.
  task automatic apb_write(input logic [4:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    check_val("wr_ready", {31'd0, PREADY}, 32'd1);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    $display("WR addr=0x%02h data=0x%08h", addr, data);
  endtask

  task automatic apb_read(input logic [4:0] addr, output logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr; PWDATA = 32'd0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    check_val("rd_wait", {31'd0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    check_val("rd_ready", {31'd0, PREADY}, 32'd1);
    data = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check_val("rd_done", {31'd0, PREADY}, 32'd0);
    $display("RD addr=0x%02h data=0x%08h", addr, data);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 5'd0; PWDATA = 32'd0;
    #1 PRESET = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check_val("rst_pready", {31'd0, PREADY}, 32'd0);
    check_val("rst_prdata", PRDATA, 32'd0);
    PRESET = 1'b1;
    idle(1);
    apb_read(5'h04, rd); check_val("rst_tcnt", rd, 32'd0);
    apb_read(5'h08, rd); check_val("rst_psc", rd, 32'd0);
    apb_read(5'h0C, rd); check_val("rst_arr", rd, 32'hFFFF_FFFF);
`ifdef APB_TIMER_IRQ_EN
    check_val("rst_irq", {31'd0, irq}, 32'd0);
`endif

    // PSC=2: tick every 3 enabled edges; 15 enabled edges -> TCNT=5.
    apb_write(5'h08, 32'h2);
    apb_write(5'h0C, 32'h5);
    apb_write(5'h00, 32'h1);
    idle(12);
    apb_write(5'h00, 32'h0);
    apb_read(5'h04, rd); check_val("run15_tcnt", rd, 32'd5);
    idle(10);
    apb_read(5'h04, rd); check_val("frozen_tcnt", rd, 32'd5);
`ifdef APB_TIMER_IRQ_EN
    apb_read(5'h10, rd); check_val("pre_wrap_isr", rd, 32'd0);
`endif

    // Three more enabled edges: tick at TCNT=ARR wraps to 0 and sets OVF.
    apb_write(5'h00, 32'h1);
    apb_write(5'h00, 32'h0);
    apb_read(5'h04, rd); check_val("wrap_tcnt", rd, 32'd0);
`ifdef APB_TIMER_IRQ_EN
    apb_read(5'h10, rd); check_val("wrap_isr", rd, 32'd1);
    check_val("wrap_irq", {31'd0, irq}, 32'd1);
    apb_write(5'h10, 32'h1);
    apb_read(5'h10, rd); check_val("w1c_isr", rd, 32'd0);
    check_val("w1c_irq", {31'd0, irq}, 32'd0);
`endif

    // Seven enabled edges from prescaler 0 -> TCNT=2, prescaler=1.
    apb_write(5'h00, 32'h1);
    idle(4);
    apb_write(5'h00, 32'h0);
    apb_read(5'h04, rd); check_val("run7_tcnt", rd, 32'd2);

    // Enable, then CLR|EN lands exactly on a tick edge; 3 more edges -> TCNT=1.
    apb_write(5'h00, 32'h1);
    idle(2);
    apb_write(5'h00, 32'h3);
    apb_write(5'h00, 32'h0);
    apb_read(5'h04, rd); check_val("clr_on_tick_tcnt", rd, 32'd1);

    // PSC=0 ticks every edge; ARR lowered to 4 while TCNT=8 forces a wrap.
    apb_write(5'h00, 32'h2);
    apb_write(5'h08, 32'h0);
    apb_write(5'h0C, 32'hFF);
    apb_write(5'h00, 32'h1);
    idle(5);
    apb_write(5'h0C, 32'h4);
    apb_write(5'h00, 32'h0);
    apb_read(5'h04, rd); check_val("arr_drop_tcnt", rd, 32'd2);
`ifdef APB_TIMER_IRQ_EN
    apb_read(5'h10, rd); check_val("arr_drop_isr", rd, 32'd1);
`endif

    // Unmapped, misaligned and read-only accesses.
    apb_read(5'h14, rd); check_val("unmapped_rd", rd, 32'd0);
    apb_write(5'h14, 32'hFFFF_FFFF);
    apb_write(5'h09, 32'h77);
    apb_write(5'h0D, 32'h99);
    apb_write(5'h04, 32'h55);
    apb_read(5'h01, rd); check_val("misaligned_rd", rd, 32'd0);
    apb_read(5'h00, rd); check_val("tcr_rd", rd, 32'd0);
`ifndef APB_TIMER_IRQ_EN
    apb_read(5'h10, rd); check_val("isr_absent_rd", rd, 32'd0);
`endif
    apb_read(5'h08, rd); check_val("keep_psc", rd, 32'd0);
    apb_read(5'h04, rd); check_val("keep_tcnt", rd, 32'd2);
    apb_read(5'h0C, rd); check_val("keep_arr", rd, 32'd4);
`ifdef APB_TIMER_IRQ_EN
    check_val("keep_irq", {31'd0, irq}, 32'd1);
`endif

    // Reset asserted in the first access cycle of an ARR write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h0C; PWDATA = 32'h33;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESET = 1'b0;
    #1;
    check_val("arst_pready", {31'd0, PREADY}, 32'd0);
    check_val("arst_prdata", PRDATA, 32'd0);
`ifdef APB_TIMER_IRQ_EN
    check_val("arst_irq", {31'd0, irq}, 32'd0);
`endif
    @(posedge PCLK); #1;
    check_val("arst_hold_pready", {31'd0, PREADY}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    idle(1);
    apb_read(5'h0C, rd); check_val("arst_arr", rd, 32'hFFFF_FFFF);
    apb_read(5'h08, rd); check_val("arst_psc", rd, 32'd0);
    apb_read(5'h04, rd); check_val("arst_tcnt", rd, 32'd0);
`ifdef APB_TIMER_IRQ_EN
    apb_read(5'h10, rd); check_val("arst_isr", rd, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0x%08h exp=0x%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

endmodule
